// File: rtl/input_loader_pkg.sv
// Shared definitions for the input loader: default geometry, FSM state
// encodings and a small width helper used by the controller, the element
// register file and the bus interface.
package input_loader_pkg;

    localparam int unsigned N_DEF = 4;   // elements per run
    localparam int unsigned W_DEF = 16;  // bits per element

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Width of an element index; never narrower than one bit so a
    // single-element configuration still has a legal index signal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/input_loader_if.sv
// Bus bundle between the input loader and its surroundings.
//   in_valid/in_data/in_ready : upstream valid/ready word stream
//   start/done                : run handshake with the network controller
//   x_flat                    : buffered elements, element i at [i*W +: W]
//   busy, count               : run status and number of buffered words
// slave  : the loader side
// master : the upstream / controller side
interface input_loader_if
    import input_loader_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF
) ();

    localparam int unsigned CW = $clog2(N + 1);

    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic             done;
    logic             start;
    logic [N*W-1:0]   x_flat;
    logic             busy;
    logic [CW-1:0]    count;

    modport slave (
        input  in_valid, in_data, done,
        output in_ready, start, x_flat, busy, count
    );

    modport master (
        output in_valid, in_data, done,
        input  in_ready, start, x_flat, busy, count
    );

endinterface

// File: rtl/input_loader_x_regfile.sv
// Element storage for the input loader: N registers of W bits with a single
// write port (enable + index) and a flat read-out of all elements.
//   clk, rst_n : clock, asynchronous active-low reset (clears all elements)
//   wr_en      : write wr_data into element wr_idx this cycle
//   wr_idx     : element index, always < N when wr_en is high
//   wr_data    : word to store
//   x_flat     : all elements, element i at [i*W +: W]
module x_regfile
    import input_loader_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned W  = W_DEF,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_idx,
    input  logic [W-1:0]    wr_data,
    output logic [N*W-1:0]  x_flat
);

    logic [N-1:0][W-1:0] mem_q, mem_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first; otherwise the
        // unwritten paths would hold their value and infer a latch.
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    // NOTE: this storage is reset on purpose -- the read-out must be zero
    // after reset, so it cannot be left as an unreset RAM-style array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Packed element i already occupies bits [i*W +: W].
    assign x_flat = mem_q;

endmodule

// File: rtl/input_loader.sv
// Input loader: collects N words from an upstream valid/ready stream into a
// register file, then issues a one-cycle start to the network controller and
// holds the buffered elements stable until the controller reports done.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : input_loader_if.slave (stream, start/done handshake, x_flat,
//          busy, count)
module input_loader
    import input_loader_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input_loader_if.slave  bus
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned IW = idx_width(N);

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_en;
    logic [IW-1:0]   wr_idx;

    // Next-state, counter and write-enable. Words are only taken in FILL, so
    // the buffer cannot change from FIRE until done returns the FSM to FILL;
    // done outside WAIT is simply not looked at.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en   = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                if (bus.in_valid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(N - 1)) begin
                        state_d = ST_FIRE;
                    end
                end
            end
            ST_FIRE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.done) begin
                    count_d = '0;
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
                count_d = '0;
            end
        endcase
    end

    // In FILL count_q is always below N, so its low bits are the slot index.
    assign wr_idx = count_q[IW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FILL;
            count_q <= '0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    x_regfile #(
        .N  (N),
        .W  (W),
        .IW (IW)
    ) u_x_regfile (
        .clk     (clk),
        .rst_n   (rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (bus.in_data),
        .x_flat  (bus.x_flat)
    );

    // Status decodes come straight from the state register, which keeps
    // done from reaching in_ready within the same cycle.
    assign bus.in_ready = (state_q == ST_FILL);
    assign bus.start    = (state_q == ST_FIRE);
    assign bus.busy     = (state_q != ST_FILL);
    assign bus.count    = count_q;

endmodule

// File: tb/tb_input_loader.sv
// Directed bench for input_loader: a reference model of the element buffer
// pushes the expected x_flat into a scoreboard queue when the N-th word of a
// run is driven; the entry is popped and compared when start is observed.
module tb_input_loader;
    import input_loader_pkg::*;

    localparam int unsigned N = N_DEF;
    localparam int unsigned W = W_DEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    input_loader_if #(.N(N), .W(W)) bus ();

    input_loader #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int              n_assert = 0;
    int              n_fail   = 0;
    logic [N*W-1:0]  sb_q[$];
    logic [W-1:0]    exp_x[N];
    int              exp_cnt  = 0;
    int              n_starts = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] model_flat();
        logic [N*W-1:0] f;
        for (int i = 0; i < N; i++) f[i*W +: W] = exp_x[i];
        return f;
    endfunction

    // Sample point: 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word for one edge (loader is expected to be in FILL).
    task automatic accept(input logic [W-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        exp_x[exp_cnt] = d;
        exp_cnt++;
        if (exp_cnt == N) sb_q.push_back(model_flat());
    endtask

    // Called in the cycle start is expected high.
    task automatic check_fire(input string tag);
        logic [N*W-1:0] e;
        chk({tag, "_start"}, bus.start, 1'b1);
        chk({tag, "_busy"}, bus.busy, 1'b1);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
        chk({tag, "_count"}, bus.count, N);
        chk({tag, "_sb_nonempty"}, (sb_q.size() != 0), 1'b1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_x_flat"}, bus.x_flat, e);
        end
    endtask

    // One done pulse while in WAIT; the loader returns to FILL.
    task automatic pulse_done();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        exp_cnt  = 0;
        chk("done_in_ready", bus.in_ready, 1'b1);
        chk("done_count", bus.count, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.done     = 1'b0;
        for (int i = 0; i < N; i++) exp_x[i] = '0;

        // Reset, with a done pulse in progress across release.
        repeat (3) step();
        chk("rst_count", bus.count, 0);
        chk("rst_x_flat", bus.x_flat, 0);
        chk("rst_start", bus.start, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        bus.done = 1'b1;
        step();
        rst = 1'b1;
        chk("rel_in_ready", bus.in_ready, 1'b1);
        step();
        bus.done = 1'b0;
        chk("rel_done_ignored_busy", bus.busy, 1'b0);
        chk("rel_done_ignored_ready", bus.in_ready, 1'b1);

        // Four back-to-back words; start in the 5th cycle.
        accept(16'h0010);
        accept(16'h0020);
        accept(16'h0030);
        accept(16'h0040);
        bus.in_valid = 1'b0;
        check_fire("b2b");
        chk("b2b_x_literal", bus.x_flat, 64'h0040_0030_0020_0010);
        step();
        chk("b2b_start_once", bus.start, 1'b0);
        chk("b2b_busy_wait", bus.busy, 1'b1);

        // Held word in WAIT is neither stored nor counted.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("wait_x_flat", bus.x_flat, model_flat());
            chk("wait_in_ready", bus.in_ready, 1'b0);
            chk("wait_count", bus.count, N);
            chk("wait_start", bus.start, 1'b0);
        end

        // done and in_valid together: word taken only one cycle later.
        bus.in_data = 16'h0005;
        pulse_done();
        chk("same_cyc_x_flat", bus.x_flat, model_flat());
        accept(16'h0005);
        bus.in_valid = 1'b0;
        chk("same_cyc_count", bus.count, 1);
        chk("same_cyc_retain", bus.x_flat, model_flat());

        // done during FILL is ignored.
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("fill_done_count", bus.count, 1);
        chk("fill_done_busy", bus.busy, 1'b0);
        chk("fill_done_in_ready", bus.in_ready, 1'b1);

        // Complete the run; done asserted during FIRE is ignored.
        accept(16'h0006);
        accept(16'h0007);
        accept(16'h0008);
        bus.in_valid = 1'b0;
        check_fire("mixed");
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("fire_done_busy", bus.busy, 1'b1);
        chk("fire_done_in_ready", bus.in_ready, 1'b0);
        chk("fire_done_count", bus.count, N);
        pulse_done();

        // Same four words with two idle cycles between them.
        for (int i = 0; i < N; i++) begin
            accept(W'(16 * (i + 1)));
            bus.in_valid = 1'b0;
            chk("gap_count", bus.count, i + 1);
            if (i < N - 1) begin
                chk("gap_no_start", bus.start, 1'b0);
                repeat (2) begin
                    step();
                    chk("gap_idle_start", bus.start, 1'b0);
                    chk("gap_idle_count", bus.count, i + 1);
                end
            end
        end
        check_fire("gap");
        step();
        pulse_done();

        // Reset after two words, then a full refill.
        accept(16'hAAAA);
        accept(16'hBBBB);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_x_flat", bus.x_flat, 0);
        chk("mid_rst_start", bus.start, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        for (int i = 0; i < N; i++) exp_x[i] = '0;
        exp_cnt = 0;
        step();
        rst = 1'b1;
        chk("mid_rel_in_ready", bus.in_ready, 1'b1);
        accept(16'h0001);
        accept(16'h0002);
        accept(16'h0003);
        accept(16'h0004);
        bus.in_valid = 1'b0;
        check_fire("refill");
        n_starts = 1;
        repeat (6) begin
            step();
            if (bus.start === 1'b1) n_starts++;
        end
        chk("refill_single_start", n_starts, 1);
        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/input_loader.md
INPUT_LOADER -- requirements
Module: input_loader

Interface
REQ-001 Parameter: N, 4, number of input elements per run.
REQ-002 Parameter: W, 16, bit width of each input element.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_data  input  W  upstream word.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 done  input  1  run-complete pulse from the network controller.
REQ-010 start  output  1  one-cycle run request to the network controller.
REQ-011 x_flat  output  N*W  buffered elements; element i at bits [i*W +: W].
REQ-012 busy  output  1  high from the start pulse until done is accepted.
REQ-013 count  output  clog2(N+1)  number of words currently buffered.

Function
REQ-014 The block SHALL implement three states: FILL, FIRE, WAIT.
REQ-015 FILL: in_ready=1; each cycle with in_valid=1, write in_data to element[count] and increment count.
REQ-016 FILL -> FIRE: on the cycle the N-th word is accepted; count then equals N.
REQ-017 FIRE: start=1 for exactly one cycle, in_ready=0; FIRE -> WAIT unconditionally.
REQ-018 WAIT: in_ready=0, busy=1; on done=1, clear count to 0 and go to FILL.
REQ-019 busy SHALL be 1 in FIRE and WAIT, and 0 in FILL.
REQ-020 x_flat SHALL be registered and SHALL NOT change from the FIRE cycle until the cycle after done is seen in WAIT.
REQ-021 Words presented while in_ready=0 SHALL be neither stored nor counted; upstream holds them under valid/ready.
REQ-022 done in FILL or FIRE SHALL be ignored.
REQ-023 done and in_valid in the same WAIT cycle: the word SHALL NOT be accepted; it is accepted in FILL, one cycle later.
REQ-024 First word after returning to FILL SHALL write element 0; count never exceeds N and never wraps.
REQ-025 Elements not yet overwritten in FILL SHALL retain their previous-run values.
REQ-026 Latency: start SHALL rise in the cycle after the N-th accepted word.

Reset
REQ-027 On rst=0 (any state, including mid-fill or WAIT): state=FILL, count=0, start=0, busy=0, x_flat=0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst is released.
REQ-029 A done pulse in progress during reset SHALL have no effect after release.

Structure
REQ-030 State encodings FILL/FIRE/WAIT and the N, W defaults SHALL live in a shared package/include file also used by the controller and datapath.
REQ-031 The element storage SHALL be a sub-module, x_regfile: N×W registers, write-enable plus index, flat read-out.
REQ-032 The FSM and counter SHALL live in input_loader; no combinational path from done to in_ready except through the state register.

Verification
REQ-033 After reset, send 4 back-to-back words 0x0010, 0x0020, 0x0030, 0x0040 -> start pulses once in the 5th cycle; x_flat = 0x0040_0030_0020_0010; busy=1.
REQ-034 Same 4 words with in_valid gaps of 2 cycles -> count steps 1, 2, 3, 4; start only after word 4.
REQ-035 In WAIT, hold in_valid=1 with data 0xFFFF for 10 cycles, then pulse done -> x_flat unchanged throughout; in_ready=0; no count change until FILL.
REQ-036 Same cycle: done=1 and in_valid=1 with 0x0005 -> word not taken; next cycle it is taken as element 0, count=1.
REQ-037 Assert rst low after 2 accepted words -> count=0, x_flat=0, no start; full refill then yields a normal single start.
REQ-038 done pulsed during FILL -> no state change; count preserved.
